// File: rtl/fetch_bundle_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_bundle_queue_pkg
// Shared core constants used by fetch, decode and the fetch bundle queue.
// Also defines the packed layout of one fetch bundle (FBQ entry). Decode
// unpacks the same layout.
// ---------------------------------------------------------------------------
package fetch_bundle_queue_pkg;

  localparam int ADDR_LEN    = 32;
  localparam int INSN_LEN    = 32;
  localparam int GSH_BHR_LEN = 10;

  // One bundle: pc, npc, two instructions, invalid2 flag, prediction, BHR.
  localparam int FBQ_ENTRY_LEN = 2 * ADDR_LEN + 2 * INSN_LEN + 2 + GSH_BHR_LEN;

  typedef struct packed {
    logic [ADDR_LEN-1:0]    pc;
    logic [ADDR_LEN-1:0]    npc;
    logic [INSN_LEN-1:0]    inst1;
    logic [INSN_LEN-1:0]    inst2;
    logic                   invalid2;
    logic                   pred_cond;
    logic [GSH_BHR_LEN-1:0] bhr;
  } fbq_entry_t;

endpackage

// File: rtl/fetch_bundle_queue_storage.sv
// ---------------------------------------------------------------------------
// fbq_storage
// DEPTH x W register array with one synchronous write port and one
// combinational read port. Reset clears every entry.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   we_i, waddr_i     write enable and write index
//   wdata_i           write data
//   raddr_i, rdata_o  read index and combinational read data
// ---------------------------------------------------------------------------
module fbq_storage
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = FBQ_ENTRY_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_bundle_queue.sv
// ---------------------------------------------------------------------------
// fetch_bundle_queue
// Decoupling queue between fetch and decode. Buffers up to DEPTH fetch
// bundles and presents the oldest to decode via valid/ready. enq_ready
// depends only on registered occupancy, so decode's ready never reaches
// fetch combinationally. flush (misprediction) empties the queue.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   flush                  misprediction kill, drops all bundles
//   enq_valid / enq_ready  fetch handshake (fetch holds pc while !enq_ready)
//   enq_*                  bundle fields from fetch
//   deq_valid / deq_ready  decode handshake
//   deq_*                  head bundle fields (combinational read)
//   count                  occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_bundle_queue
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [ADDR_LEN-1:0]    enq_pc,
  input  logic [ADDR_LEN-1:0]    enq_npc,
  input  logic [INSN_LEN-1:0]    enq_inst1,
  input  logic [INSN_LEN-1:0]    enq_inst2,
  input  logic                   enq_invalid2,
  input  logic                   enq_pred_cond,
  input  logic [GSH_BHR_LEN-1:0] enq_bhr,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [ADDR_LEN-1:0]    deq_pc,
  output logic [ADDR_LEN-1:0]    deq_npc,
  output logic [INSN_LEN-1:0]    deq_inst1,
  output logic [INSN_LEN-1:0]    deq_inst2,
  output logic                   deq_invalid2,
  output logic                   deq_pred_cond,
  output logic [GSH_BHR_LEN-1:0] deq_bhr,
  output logic [PTR_W:0]         count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_enq_s, do_deq_s;
  fbq_entry_t       wr_entry_s, rd_entry_s;

  assign enq_ready = (count_q != FULL_CNT);
  assign deq_valid = (count_q != {(PTR_W + 1){1'b0}});
  assign do_enq_s  = enq_valid & enq_ready & ~flush;
  assign do_deq_s  = deq_valid & deq_ready & ~flush;
  assign count     = count_q;

  // Pointer and occupancy next state; flush overrides any transfer.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = {PTR_W{1'b0}};
      rptr_d  = {PTR_W{1'b0}};
      count_d = {(PTR_W + 1){1'b0}};
    end else begin
      // Pointers wrap naturally because DEPTH == 2**PTR_W.
      if (do_enq_s) wptr_d = wptr_q + PTR_ONE;
      else          wptr_d = wptr_q;
      if (do_deq_s) rptr_d = rptr_q + PTR_ONE;
      else          rptr_d = rptr_q;
      case ({do_enq_s, do_deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W + 1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    wr_entry_s           = '0;
    wr_entry_s.pc        = enq_pc;
    wr_entry_s.npc       = enq_npc;
    wr_entry_s.inst1     = enq_inst1;
    wr_entry_s.inst2     = enq_inst2;
    wr_entry_s.invalid2  = enq_invalid2;
    wr_entry_s.pred_cond = enq_pred_cond;
    wr_entry_s.bhr       = enq_bhr;
  end

  fbq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (FBQ_ENTRY_LEN)
  ) u_storage (
    .clk     (clk),
    .reset   (reset),
    .we_i    (do_enq_s),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry_s),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry_s)
  );

  assign deq_pc        = rd_entry_s.pc;
  assign deq_npc       = rd_entry_s.npc;
  assign deq_inst1     = rd_entry_s.inst1;
  assign deq_inst2     = rd_entry_s.inst2;
  assign deq_invalid2  = rd_entry_s.invalid2;
  assign deq_pred_cond = rd_entry_s.pred_cond;
  assign deq_bhr       = rd_entry_s.bhr;

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
- Decoupling queue between the fetch stage (PC/imem/select/BTB/gshare) and decode.
- Each cycle the fetch stage produces one bundle: pc, up to two instructions, second-slot invalid flag, branch prediction, npc and the BHR snapshot. This block buffers up to DEPTH bundles and presents the oldest one to decode with a valid/ready handshake.
- Generates the fetch stall (PC hold) and drops all buffered bundles on a branch misprediction flush.

Parameters:
- DEPTH, 4, number of bundle entries; must be a power of two, >= 2.
- PTR_W, 2, log2(DEPTH); width of the read and write pointers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  misprediction kill (prmiss); empties the queue.
- enq_valid  in  1  fetch stage presents a bundle this cycle.
- enq_ready  out  1  queue can accept a bundle; fetch holds pc when low.
- enq_pc  in  ADDR_LEN  PC of the bundle.
- enq_npc  in  ADDR_LEN  predicted next PC of the bundle.
- enq_inst1  in  INSN_LEN  first instruction.
- enq_inst2  in  INSN_LEN  second instruction.
- enq_invalid2  in  1  second slot is not valid.
- enq_pred_cond  in  1  branch predicted taken.
- enq_bhr  in  GSH_BHR_LEN  BHR snapshot used for the prediction.
- deq_valid  out  1  head bundle is available.
- deq_ready  in  1  decode consumes the head bundle this cycle.
- deq_pc, deq_npc, deq_inst1, deq_inst2, deq_invalid2, deq_pred_cond, deq_bhr  out  (same widths as enq_*)  head bundle fields.
- count  out  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- All state changes occur on the rising edge of clk. Reset is synchronous, active-high.
- Reset: wptr = 0, rptr = 0, count = 0, every storage entry = 0.
  - Hence deq_valid = 0, enq_ready = 1, and all deq_* fields = 0 in the cycle after reset.
- enq_ready = (count != DEPTH).
  - Registered-state function only; it must not depend on deq_ready, so there is no combinational path from decode to fetch.
- deq_valid = (count != 0).
- deq_* fields are a combinational read of entry[rptr]. Zero-latency read; a bundle is visible the cycle after it is enqueued.
- Handshake:
  - do_enq = enq_valid & enq_ready & ~flush.
  - do_deq = deq_valid & deq_ready & ~flush.
- On do_enq: entry[wptr] <= enq_* fields; wptr <= wptr + 1, wrapping modulo DEPTH.
- On do_deq: rptr <= rptr + 1, wrapping modulo DEPTH.
- count update:
  - Increments on do_enq & ~do_deq.
  - Decrements on do_deq & ~do_enq.
  - Unchanged when both or neither occur.
- Simultaneous enq and deq:
  - When 0 < count < DEPTH: both occur and count is unchanged.
  - When count == DEPTH: only deq occurs, because enq_ready is 0; count drops to DEPTH-1.
  - When count == 0: only enq occurs, because there is no bypass and deq_valid is 0.
- flush has highest priority.
  - Next cycle: wptr = rptr = count = 0. Any bundle offered or consumed in the same cycle is discarded.
  - Storage contents need not be cleared. deq_* may show stale data while deq_valid = 0.
- reset has priority over flush.
- Protocol violations:
  - enq_valid while enq_ready = 0 is ignored; the fetch stage must hold.
  - deq_ready while deq_valid = 0 is ignored.
- Fields pass through unmodified; bit-exact equality between enqueued and dequeued fields is required, with FIFO order preserved.

Decomposition:
- ADDR_LEN, INSN_LEN and GSH_BHR_LEN come from the shared constants header. No new global constants.
- Add a derived FBQ_ENTRY_LEN = 2*ADDR_LEN + 2*INSN_LEN + 2 + GSH_BHR_LEN to the shared header. Decode uses the same packing.
- One sub-module is natural: fbq_storage, a DEPTH x FBQ_ENTRY_LEN register array with one synchronous write port and one combinational read port.
  - The top level holds the pointers, count and handshake logic, and packs and unpacks the fields.

Test Plan:
- Basic order: after reset, enqueue bundles with pc = 0x00, 0x08, 0x10 and deq_ready = 1 from cycle 5. Dequeued pc sequence must be 0x00, 0x08, 0x10 with all fields matching. count must peak at 3, then return to 0.
- Full/backpressure: deq_ready = 0, enqueue 5 bundles. count reaches 4 and enq_ready = 0 after the 4th. The 5th is not stored. Raising deq_ready drains exactly 4 bundles in order.
- Simultaneous at full: count = 4, enq_valid = 1 and deq_ready = 1 in the same cycle. Head is dequeued, the new bundle is not accepted, count = 3. The next cycle the bundle is accepted and count stays 3.
- Wrap-around: stream 10 bundles (pc = 0x100 + 8*i) with deq_ready toggling 1,0,1,0. All 10 emerge in order with no loss or duplication; pointers wrap at least twice.
- Flush: with count = 3, assert flush together with enq_valid and deq_ready. Next cycle count = 0, deq_valid = 0, enq_ready = 1. The next enqueued bundle (pc = 0x200) is the next one dequeued.
- Reset mid-operation: with count = 2, assert reset for one cycle. Next cycle count = 0, deq_valid = 0 and all deq_* = 0.
